ddr_req_arbiter: RTL and testbench

Arbitrates DDR access between the five traffic sources of the HDR pipeline: VGA read, camera write, HDR read, HDR write and UART read. It issues one command at a time to the DDR command interface and tracks outstanding reads in an internal tag queue, so that returned read data is routed back to the requester that asked for it. VGA read has absolute priority because it is real-time. The other four sources share the remaining bandwidth round-robin, with a starvation override that can pre-empt VGA.

---
 rtl/ddr_req_arbiter.sv | 239 +++++++++++++++++++++++
 tb/tb_ddr_req_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_req_arbiter.sv
// ddr_req_arbiter: five-source DDR command arbiter (VGA priority, round-robin
// for the rest with starvation override) plus a read-tag FIFO that routes
// returned read beats back to the requester that issued them.
module ddr_req_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned STARVE_LIMIT    = 64,
    parameter logic [3:0]  CMD_READ        = 4'b0011,
    parameter logic [3:0]  CMD_WRITE       = 4'b0100
) (
    input  logic         clk_133M,
    input  logic         rst_n_133M,
    input  logic         init_done,
    input  logic         vga_rd_req,
    input  logic [24:0]  vga_rd_address,
    input  logic         uart_rd_req,
    input  logic [24:0]  uart_rd_address,
    input  logic         hdr_rd_req,
    input  logic [24:0]  hdr_rd_address,
    input  logic         cam_wr_req,
    input  logic [24:0]  cam_wr_address,
    input  logic [127:0] cam_wr_data,
    input  logic         hdr_wr_req,
    input  logic [24:0]  hdr_wr_address,
    input  logic [127:0] hdr_wr_data,
    output logic         vga_rd_ack,
    output logic         cam_wr_ack,
    output logic         hdr_rd_ack,
    output logic         hdr_wr_ack,
    output logic         uart_rd_ack,
    input  logic         cmd_busy,
    output logic [3:0]   cmd,
    output logic         cmd_valid,
    output logic [24:0]  ddr_address,
    output logic [127:0] ddr_wr_data,
    input  logic         ddr_data_valid,
    input  logic [127:0] ddr_rd_data,
    output logic [127:0] vga_rd_data,
    output logic [127:0] hdr_rd_data,
    output logic [127:0] uart_rd_data,
    output logic         vga_data_valid,
    output logic         hdr_rd_valid,
    output logic         uart_data_valid,
    output logic         rd_underflow
);

    localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD} state_t;
    typedef enum logic [2:0] {SRC_VGA, SRC_CAM, SRC_HDR_RD, SRC_HDR_WR, SRC_UART} src_t;

    state_t        state_q, state_d;
    src_t          win_q, win_d;
    logic [3:0]    cmd_q, cmd_d;
    logic [24:0]   addr_q, addr_d;
    logic [127:0]  wdata_q, wdata_d;
    logic [1:0]    rr_q, rr_d;
    logic [SW-1:0] starve_q [4];
    logic [1:0]    tag_mem_q [MAX_OUTSTANDING];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q;
    logic          underflow_q;
    logic [127:0]  vga_data_q, hdr_data_q, uart_data_q;
    logic          vga_vld_q, hdr_vld_q, uart_vld_q;

    logic          issue, win_is_rd, push, pop, rd_ok, vga_elig, found;
    logic [3:0]    nv_req, nv_elig, nv_ack;
    logic [1:0]    push_tag, pick, idx;

    // Non-VGA vectors are ordered cam wr, hdr rd, hdr wr, uart rd (bit 0..3).
    assign issue     = (state_q == S_ISSUE);
    assign win_is_rd = (win_q == SRC_VGA) || (win_q == SRC_HDR_RD) || (win_q == SRC_UART);
    assign push      = issue && win_is_rd;
    assign pop       = ddr_data_valid && (cnt_q != '0);
    assign rd_ok     = (cnt_q < CW'(MAX_OUTSTANDING));
    assign nv_req    = {uart_rd_req, hdr_wr_req, hdr_rd_req, cam_wr_req};
    assign nv_elig   = nv_req & {rd_ok, 1'b1, rd_ok, 1'b1};
    assign vga_elig  = vga_rd_req && rd_ok;
    assign nv_ack    = {issue && (win_q == SRC_UART), issue && (win_q == SRC_HDR_WR),
                        issue && (win_q == SRC_HDR_RD), issue && (win_q == SRC_CAM)};

    assign vga_rd_ack      = issue && (win_q == SRC_VGA);
    assign cam_wr_ack      = nv_ack[0];
    assign hdr_rd_ack      = nv_ack[1];
    assign hdr_wr_ack      = nv_ack[2];
    assign uart_rd_ack     = nv_ack[3];
    assign cmd_valid       = issue;
    assign cmd             = cmd_q;
    assign ddr_address     = addr_q;
    assign ddr_wr_data     = wdata_q;
    assign vga_rd_data     = vga_data_q;
    assign hdr_rd_data     = hdr_data_q;
    assign uart_rd_data    = uart_data_q;
    assign vga_data_valid  = vga_vld_q;
    assign hdr_rd_valid    = hdr_vld_q;
    assign uart_data_valid = uart_vld_q;
    assign rd_underflow    = underflow_q;

    // Tag encoding of the read being issued.
    always_comb begin
        push_tag = 2'b00;
        case (win_q)
            SRC_VGA:    push_tag = 2'b01;
            SRC_HDR_RD: push_tag = 2'b10;
            SRC_UART:   push_tag = 2'b11;
            default:    push_tag = 2'b00;
        endcase
    end

    // Next state, winner selection and capture of the winner's command.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rr_d    = rr_q;
        found   = 1'b0;
        pick    = 2'd0;
        idx     = 2'd0;
        case (state_q)
            S_IDLE: begin
                if (init_done && !cmd_busy) begin
                    for (int unsigned i = 0; i < 4; i++) begin
                        if (!found && nv_elig[i] && (starve_q[i] == SW'(STARVE_LIMIT))) begin
                            found = 1'b1;
                            pick  = 2'(i);
                        end
                    end
                    if (!found && vga_elig) begin
                        state_d = S_ISSUE;
                        win_d   = SRC_VGA;
                        cmd_d   = CMD_READ;
                        addr_d  = vga_rd_address;
                        wdata_d = '0;
                    end else begin
                        for (int unsigned k = 0; k < 4; k++) begin
                            idx = rr_q + 2'(k);
                            if (!found && nv_elig[idx]) begin
                                found = 1'b1;
                                pick  = idx;
                            end
                        end
                        if (found) begin
                            state_d = S_ISSUE;
                            win_d   = src_t'(3'(pick) + 3'd1);
                            rr_d    = pick + 2'd1;
                            case (pick)
                                2'd0: begin cmd_d = CMD_WRITE; addr_d = cam_wr_address;  wdata_d = cam_wr_data; end
                                2'd1: begin cmd_d = CMD_READ;  addr_d = hdr_rd_address;  wdata_d = '0;          end
                                2'd2: begin cmd_d = CMD_WRITE; addr_d = hdr_wr_address;  wdata_d = hdr_wr_data; end
                                default: begin cmd_d = CMD_READ; addr_d = uart_rd_address; wdata_d = '0;        end
                            endcase
                        end
                    end
                end
            end
            S_ISSUE: state_d = S_HOLD;
            S_HOLD:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM and command registers.
    always_ff @(posedge clk_133M) begin
        if (!rst_n_133M) begin
            state_q <= S_IDLE;
            win_q   <= SRC_VGA;
            cmd_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rr_q    <= rr_d;
        end
    end

    // Starvation counters: count waiting cycles, saturate, clear on ack or idle request.
    always_ff @(posedge clk_133M) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (!rst_n_133M || !nv_req[i] || nv_ack[i]) begin
                starve_q[i] <= '0;
            end else if (starve_q[i] != SW'(STARVE_LIMIT)) begin
                starve_q[i] <= starve_q[i] + 1'b1;
            end
        end
    end

    // Tag FIFO pointers, occupancy and sticky underflow flag.
    always_ff @(posedge clk_133M) begin
        if (!rst_n_133M) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            underflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (ddr_data_valid && !pop) underflow_q <= 1'b1;
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
        end
    end

    // Tag FIFO storage; entries are only read while the FIFO is non-empty.
    always_ff @(posedge clk_133M) begin
        if (push) tag_mem_q[wr_ptr_q] <= push_tag;
    end

    // Route each returned beat to the requester named by the oldest tag.
    always_ff @(posedge clk_133M) begin
        if (!rst_n_133M) begin
            vga_data_q  <= '0;
            hdr_data_q  <= '0;
            uart_data_q <= '0;
            vga_vld_q   <= 1'b0;
            hdr_vld_q   <= 1'b0;
            uart_vld_q  <= 1'b0;
        end else begin
            vga_vld_q  <= 1'b0;
            hdr_vld_q  <= 1'b0;
            uart_vld_q <= 1'b0;
            if (pop) begin
                case (tag_mem_q[rd_ptr_q])
                    2'b01:   begin vga_data_q  <= ddr_rd_data; vga_vld_q  <= 1'b1; end
                    2'b10:   begin hdr_data_q  <= ddr_rd_data; hdr_vld_q  <= 1'b1; end
                    2'b11:   begin uart_data_q <= ddr_rd_data; uart_vld_q <= 1'b1; end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ddr_req_arbiter.sv
// Self-checking bench for ddr_req_arbiter: directed scenarios plus a random
// phase, every cycle compared against a source-level reference model.
module tb_ddr_req_arbiter;
    localparam int MAXO = 8;
    localparam int LIM  = 64;
    localparam logic [3:0] C_RD = 4'b0011;
    localparam logic [3:0] C_WR = 4'b0100;

    logic clk_133M = 1'b0;
    always #4 clk_133M = ~clk_133M;

    logic         rst_n_133M, init_done, cmd_busy, ddr_data_valid;
    logic         vga_rd_req, uart_rd_req, hdr_rd_req, cam_wr_req, hdr_wr_req;
    logic [24:0]  vga_rd_address, uart_rd_address, hdr_rd_address, cam_wr_address, hdr_wr_address;
    logic [127:0] cam_wr_data, hdr_wr_data, ddr_rd_data;
    logic         vga_rd_ack, cam_wr_ack, hdr_rd_ack, hdr_wr_ack, uart_rd_ack;
    logic [3:0]   cmd;
    logic         cmd_valid;
    logic [24:0]  ddr_address;
    logic [127:0] ddr_wr_data, vga_rd_data, hdr_rd_data, uart_rd_data;
    logic         vga_data_valid, hdr_rd_valid, uart_data_valid, rd_underflow;

    ddr_req_arbiter #(.MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(LIM), .CMD_READ(C_RD), .CMD_WRITE(C_WR)) dut (
        .clk_133M(clk_133M), .rst_n_133M(rst_n_133M), .init_done(init_done),
        .vga_rd_req(vga_rd_req), .vga_rd_address(vga_rd_address),
        .uart_rd_req(uart_rd_req), .uart_rd_address(uart_rd_address),
        .hdr_rd_req(hdr_rd_req), .hdr_rd_address(hdr_rd_address),
        .cam_wr_req(cam_wr_req), .cam_wr_address(cam_wr_address), .cam_wr_data(cam_wr_data),
        .hdr_wr_req(hdr_wr_req), .hdr_wr_address(hdr_wr_address), .hdr_wr_data(hdr_wr_data),
        .vga_rd_ack(vga_rd_ack), .cam_wr_ack(cam_wr_ack), .hdr_rd_ack(hdr_rd_ack),
        .hdr_wr_ack(hdr_wr_ack), .uart_rd_ack(uart_rd_ack),
        .cmd_busy(cmd_busy), .cmd(cmd), .cmd_valid(cmd_valid), .ddr_address(ddr_address),
        .ddr_wr_data(ddr_wr_data), .ddr_data_valid(ddr_data_valid), .ddr_rd_data(ddr_rd_data),
        .vga_rd_data(vga_rd_data), .hdr_rd_data(hdr_rd_data), .uart_rd_data(uart_rd_data),
        .vga_data_valid(vga_data_valid), .hdr_rd_valid(hdr_rd_valid),
        .uart_data_valid(uart_data_valid), .rd_underflow(rd_underflow)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Reference model. Sources: 0 vga rd, 1 cam wr, 2 hdr rd, 3 hdr wr, 4 uart rd.
    // m_phase: 0 arbitrating, 1 command cycle, 2 hold cycle.
    int           m_phase = 0, m_win = -1, m_ptr = 0;
    int           m_starve[4] = '{0, 0, 0, 0};
    int           m_q[$];
    logic [3:0]   m_cmd = '0;
    logic [24:0]  m_addr = '0;
    logic [127:0] m_wdata = '0, m_vd = '0, m_hd = '0, m_ud = '0;
    logic         m_vv = 1'b0, m_hv = 1'b0, m_uv = 1'b0, m_uf = 1'b0;

    function automatic bit is_read(input int s);
        return (s == 0) || (s == 2) || (s == 4);
    endfunction

    function automatic bit req_of(input int s);
        case (s)
            0: return vga_rd_req;
            1: return cam_wr_req;
            2: return hdr_rd_req;
            3: return hdr_wr_req;
            default: return uart_rd_req;
        endcase
    endfunction

    function automatic logic [24:0] addr_of(input int s);
        case (s)
            0: return vga_rd_address;
            1: return cam_wr_address;
            2: return hdr_rd_address;
            3: return hdr_wr_address;
            default: return uart_rd_address;
        endcase
    endfunction

    function automatic bit eligible(input int s);
        return req_of(s) && (!is_read(s) || (m_q.size() < MAXO));
    endfunction

    function automatic int pick_winner();
        for (int s = 1; s <= 4; s++)
            if (eligible(s) && m_starve[s-1] == LIM) return s;
        if (eligible(0)) return 0;
        for (int k = 0; k < 4; k++)
            if (eligible(1 + (m_ptr + k) % 4)) return 1 + (m_ptr + k) % 4;
        return -1;
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        int w;
        int t;
        int ns[4];
        bit push;
        if (!rst_n_133M) begin
            m_phase = 0; m_win = -1; m_ptr = 0; m_q.delete();
            foreach (m_starve[i]) m_starve[i] = 0;
            m_cmd = '0; m_addr = '0; m_wdata = '0; m_vd = '0; m_hd = '0; m_ud = '0;
            m_vv = 1'b0; m_hv = 1'b0; m_uv = 1'b0; m_uf = 1'b0;
            return;
        end
        w = -1;
        if (m_phase == 0 && init_done && !cmd_busy) w = pick_winner();
        for (int i = 0; i < 4; i++) begin
            if (!req_of(i + 1) || (m_phase == 1 && m_win == i + 1)) ns[i] = 0;
            else ns[i] = (m_starve[i] < LIM) ? m_starve[i] + 1 : LIM;
        end
        push = (m_phase == 1) && is_read(m_win);
        m_vv = 1'b0; m_hv = 1'b0; m_uv = 1'b0;
        if (ddr_data_valid) begin
            if (m_q.size() > 0) begin
                t = m_q.pop_front();
                if (t == 0)      begin m_vd = ddr_rd_data; m_vv = 1'b1; end
                else if (t == 2) begin m_hd = ddr_rd_data; m_hv = 1'b1; end
                else             begin m_ud = ddr_rd_data; m_uv = 1'b1; end
            end else begin
                m_uf = 1'b1;
            end
        end
        if (push) m_q.push_back(m_win);
        if (m_phase == 1) m_phase = 2;
        else if (m_phase == 2) m_phase = 0;
        else if (w >= 0) begin
            m_phase = 1;
            m_win   = w;
            m_cmd   = is_read(w) ? C_RD : C_WR;
            m_addr  = addr_of(w);
            m_wdata = (w == 1) ? cam_wr_data : (w == 3) ? hdr_wr_data : '0;
            if (w != 0) m_ptr = w % 4;
        end
        foreach (m_starve[i]) m_starve[i] = ns[i];
    endtask

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        chk("cmd_valid", 128'(cmd_valid), 128'(m_phase == 1));
        chk("cmd_addr", {99'd0, cmd, ddr_address}, {99'd0, m_cmd, m_addr});
        chk("wr_data", ddr_wr_data, m_wdata);
        chk("acks", {123'd0, uart_rd_ack, hdr_wr_ack, hdr_rd_ack, cam_wr_ack, vga_rd_ack},
            {123'd0, m_phase == 1 && m_win == 4, m_phase == 1 && m_win == 3, m_phase == 1 && m_win == 2,
             m_phase == 1 && m_win == 1, m_phase == 1 && m_win == 0});
        chk("rd_flags", {124'd0, vga_data_valid, hdr_rd_valid, uart_data_valid, rd_underflow},
            {124'd0, m_vv, m_hv, m_uv, m_uf});
        chk("vga_data", vga_rd_data, m_vd);
        chk("hdr_data", hdr_rd_data, m_hd);
        chk("uart_data", uart_rd_data, m_ud);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk_133M);
        #1;
        cyc++;
        check_outputs();
    endtask

    function automatic int ack_src();
        if (vga_rd_ack)  return 0;
        if (cam_wr_ack)  return 1;
        if (hdr_rd_ack)  return 2;
        if (hdr_wr_ack)  return 3;
        if (uart_rd_ack) return 4;
        return -1;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic set_reqs(input logic [4:0] r);
        vga_rd_req = r[0]; cam_wr_req = r[1]; hdr_rd_req = r[2]; hdr_wr_req = r[3]; uart_rd_req = r[4];
    endtask

    task automatic rand_payload();
        vga_rd_address = 25'($urandom()); uart_rd_address = 25'($urandom());
        hdr_rd_address = 25'($urandom()); cam_wr_address  = 25'($urandom());
        hdr_wr_address = 25'($urandom());
        cam_wr_data = rnd128(); hdr_wr_data = rnd128();
    endtask

    task automatic wait_any_ack(input int budget, output int src);
        src = -1;
        for (int i = 0; i < budget && src < 0; i++) begin
            step();
            src = ack_src();
        end
    endtask

    task automatic drain();
        for (int g = 0; g < 40 && m_q.size() > 0; g++) begin
            ddr_data_valid = 1'b1;
            ddr_rd_data    = rnd128();
            step();
        end
        ddr_data_valid = 1'b0;
        step();
    endtask

    task automatic issue_one(input int src);
        set_reqs(5'(1 << src));
        step();
        chk($sformatf("single_ack_src%0d", src), 128'(ack_src()), 128'(src));
        set_reqs(5'd0);
        step();
        step();
    endtask

    int           s, n, last;
    int           exp_rr[5] = '{1, 2, 3, 4, 1};
    logic [127:0] d0, d1, d2;

    initial begin
        rst_n_133M = 1'b0; init_done = 1'b0; cmd_busy = 1'b0; ddr_data_valid = 1'b0;
        ddr_rd_data = '0;
        set_reqs(5'd0);
        rand_payload();
        repeat (3) step();
        chk("reset_outputs", 128'(|{cmd_valid, cmd, ddr_address, ddr_wr_data, vga_rd_ack, cam_wr_ack,
            hdr_rd_ack, hdr_wr_ack, uart_rd_ack, rd_underflow, vga_data_valid, hdr_rd_valid,
            uart_data_valid}), 128'd0);
        rst_n_133M = 1'b1; init_done = 1'b1;
        step();

        // Single VGA read and its return beat.
        vga_rd_address = 25'h0000100;
        set_reqs(5'b00001);
        step();
        chk("vga_single_ack", 128'(vga_rd_ack), 128'd1);
        chk("vga_single_cmd", 128'(cmd), 128'(4'b0011));
        chk("vga_single_addr", 128'(ddr_address), 128'h100);
        chk("vga_single_wdata", ddr_wr_data, 128'd0);
        set_reqs(5'd0);
        step(); step();
        ddr_data_valid = 1'b1; ddr_rd_data = {16{8'hA5}};
        step();
        ddr_data_valid = 1'b0;
        chk("vga_ret_valid", 128'(vga_data_valid), 128'd1);
        chk("vga_ret_data", vga_rd_data, {16{8'hA5}});
        step();

        // Round-robin among the four non-VGA sources, one grant every 3 cycles.
        rand_payload();
        set_reqs(5'b11110);
        last = 0;
        for (int k = 0; k < 5; k++) begin
            wait_any_ack(4, s);
            chk($sformatf("rr_order%0d", k), 128'(s), 128'(exp_rr[k]));
            if (k > 0) chk($sformatf("rr_gap%0d", k), 128'(cyc - last), 128'd3);
            last = cyc;
        end
        set_reqs(5'd0);
        step(); step();
        drain();

        // VGA held with camera: camera wins once after 64 waiting cycles.
        set_reqs(5'b00011);
        n = 0; s = -1;
        for (int i = 0; i < 200 && s != 1; i++) begin
            ddr_data_valid = (m_q.size() > 0);
            ddr_rd_data = rnd128();
            step();
            s = ack_src();
            if (s == 0) n++;
        end
        chk("starve_vga_wins", 128'(n), 128'd22);
        chk("starve_cam_wins", 128'(s), 128'd1);
        ddr_data_valid = 1'b0;
        wait_any_ack(4, s);
        chk("starve_vga_resumes", 128'(s), 128'd0);
        set_reqs(5'd0);
        step(); step();
        drain();

        // Fill the tag queue: 9th read blocked, writes still granted.
        set_reqs(5'b00001);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (ack_src() == 0) n++;
        end
        chk("full_eight_reads", 128'(n), 128'd8);
        rand_payload();
        set_reqs(5'b01001);
        wait_any_ack(4, s);
        chk("full_write_granted", 128'(s), 128'd3);
        set_reqs(5'b00001);
        step(); step();
        ddr_data_valid = 1'b1; ddr_rd_data = rnd128();
        step();
        ddr_data_valid = 1'b0;
        chk("full_pop_routed", 128'(vga_data_valid), 128'd1);
        wait_any_ack(6, s);
        chk("full_read_after_pop", 128'(s), 128'd0);
        set_reqs(5'd0);
        step(); step();
        drain();

        // Interleaved reads routed in issue order, then an underflow beat.
        issue_one(0); issue_one(4); issue_one(2);
        d0 = rnd128(); d1 = rnd128(); d2 = rnd128();
        ddr_data_valid = 1'b1;
        ddr_rd_data = d0; step();
        chk("il_vga_valid", 128'(vga_data_valid), 128'd1);
        chk("il_vga_data", vga_rd_data, d0);
        ddr_rd_data = d1; step();
        chk("il_uart_valid", 128'(uart_data_valid), 128'd1);
        chk("il_uart_data", uart_rd_data, d1);
        ddr_rd_data = d2; step();
        chk("il_hdr_valid", 128'(hdr_rd_valid), 128'd1);
        chk("il_hdr_data", hdr_rd_data, d2);
        chk("il_no_underflow", 128'(rd_underflow), 128'd0);
        ddr_rd_data = rnd128(); step();
        ddr_data_valid = 1'b0;
        chk("il_underflow", 128'(rd_underflow), 128'd1);
        chk("il_extra_dropped", 128'({vga_data_valid, hdr_rd_valid, uart_data_valid}), 128'd0);
        step();
        chk("il_underflow_sticky", 128'(rd_underflow), 128'd1);

        // Reset during HOLD with reads outstanding.
        issue_one(0); issue_one(4);
        set_reqs(5'b00001);
        step();
        set_reqs(5'd0);
        step();
        rst_n_133M = 1'b0;
        step();
        chk("rst_hold_outputs", 128'(|{cmd_valid, cmd, ddr_address, ddr_wr_data, vga_rd_ack, cam_wr_ack,
            hdr_rd_ack, hdr_wr_ack, uart_rd_ack, rd_underflow, vga_data_valid, hdr_rd_valid,
            uart_data_valid, vga_rd_data, hdr_rd_data, uart_rd_data}), 128'd0);
        rst_n_133M = 1'b1; init_done = 1'b0;
        set_reqs(5'b00001);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (ack_src() >= 0) n++;
        end
        chk("init_low_no_ack", 128'(n), 128'd0);
        ddr_data_valid = 1'b1; ddr_rd_data = rnd128();
        step();
        ddr_data_valid = 1'b0;
        chk("rst_queue_empty", 128'(rd_underflow), 128'd1);
        chk("rst_beat_dropped", 128'({vga_data_valid, hdr_rd_valid, uart_data_valid}), 128'd0);
        init_done = 1'b1;
        wait_any_ack(4, s);
        chk("init_high_grant", 128'(s), 128'd0);
        set_reqs(5'd0);
        step(); step();
        drain();

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            rst_n_133M = ($urandom_range(0, 199) != 0);
            init_done  = ($urandom_range(0, 19) != 0);
            cmd_busy   = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) set_reqs(5'($urandom()));
            if ($urandom_range(0, 3) == 0) rand_payload();
            ddr_data_valid = (m_q.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 99) == 0);
            ddr_rd_data = rnd128();
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
